// File: rtl/alu_multicycle_if.sv
// Request/response bundle for the multicycle ALU: the launch handshake,
// operands and op code in one direction, and the registered results,
// status flags and busy/done in the other.
interface alu_multicycle_if;
    logic        start;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    modport master (
        output start, alu_ctrl, op_a, op_b,
        input  result, zero, overflow, div_by_zero, busy, done
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b,
        output result, zero, overflow, div_by_zero, busy, done
    );
endinterface

// File: rtl/alu_multicycle.sv
// 32-bit ALU with single-cycle logic/arithmetic ops and 32-iteration
// shift-add multiply and restoring divide. Operands are captured on an
// accepted start; results and flags are registered and change only on done.
module alu_multicycle (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_multicycle_if.slave      bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SLTI = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    // MUL: a_q = shifted multiplicand, b_q = shifted multiplier, acc_q = product
    // DIV: a_q = dividend shifting out / quotient shifting in,
    //      b_q = divisor, acc_q = partial remainder
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] acc_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        ovf_q;
    logic        dbz_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] alu_res_d;
    logic        alu_ovf_d;
    logic        alu_dbz_d;
    logic [31:0] sum_s;
    logic [31:0] diff_s;

    logic [31:0] mul_acc_d;
    logic [32:0] div_shift_s;
    logic        div_ge_s;
    logic [31:0] div_rem_d;
    logic [31:0] div_quo_d;

    // Single-cycle result and flags from the live inputs, used at acceptance.
    always_comb begin
        sum_s     = bus.op_a + bus.op_b;
        diff_s    = bus.op_a - bus.op_b;
        alu_res_d = 32'd0;
        alu_ovf_d = 1'b0;
        alu_dbz_d = 1'b0;
        case (bus.alu_ctrl)
            OP_ADD: begin
                alu_res_d = sum_s;
                alu_ovf_d = (bus.op_a[31] == bus.op_b[31]) && (sum_s[31] != bus.op_a[31]);
            end
            OP_SUB: begin
                alu_res_d = diff_s;
                alu_ovf_d = (bus.op_a[31] != bus.op_b[31]) && (diff_s[31] != bus.op_a[31]);
            end
            // Only reaches the result path when the divisor is zero.
            OP_DIV: begin
                alu_res_d = 32'hFFFF_FFFF;
                alu_dbz_d = 1'b1;
            end
            OP_AND:  alu_res_d = bus.op_a & bus.op_b;
            OP_OR:   alu_res_d = bus.op_a | bus.op_b;
            OP_NOR:  alu_res_d = ~(bus.op_a | bus.op_b);
            OP_SRL:  alu_res_d = bus.op_a >> bus.op_b[4:0];
            OP_SLT, OP_SLTI: begin
                if ($signed(bus.op_a) < $signed(bus.op_b)) begin
                    alu_res_d = 32'd1;
                end else begin
                    alu_res_d = 32'd0;
                end
            end
            OP_XOR:  alu_res_d = bus.op_a ^ bus.op_b;
            default: alu_res_d = 32'd0;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide.
    always_comb begin
        if (b_q[0]) begin
            mul_acc_d = acc_q + a_q;
        end else begin
            mul_acc_d = acc_q;
        end
        // Partial remainder stays below the divisor, so the shifted value fits 33 bits.
        div_shift_s = {acc_q, a_q[31]};
        div_ge_s    = (div_shift_s >= {1'b0, b_q});
        if (div_ge_s) begin
            div_rem_d = div_shift_s[31:0] - b_q;
            div_quo_d = {a_q[30:0], 1'b1};
        end else begin
            div_rem_d = div_shift_s[31:0];
            div_quo_d = {a_q[30:0], 1'b0};
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 32'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.alu_ctrl == OP_MUL ||
                            (bus.alu_ctrl == OP_DIV && bus.op_b != 32'd0)) begin
                            if (bus.alu_ctrl == OP_MUL) begin
                                state_q <= ST_MUL;
                            end else begin
                                state_q <= ST_DIV;
                            end
                            a_q    <= bus.op_a;
                            b_q    <= bus.op_b;
                            acc_q  <= 32'd0;
                            cnt_q  <= 5'd0;
                            busy_q <= 1'b1;
                        end else begin
                            result_q <= alu_res_d;
                            zero_q   <= (alu_res_d == 32'd0);
                            ovf_q    <= alu_ovf_d;
                            dbz_q    <= alu_dbz_d;
                            done_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_acc_d;
                    a_q   <= {a_q[30:0], 1'b0};
                    b_q   <= {1'b0, b_q[31:1]};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= mul_acc_d;
                        zero_q   <= (mul_acc_d == 32'd0);
                        ovf_q    <= 1'b0;
                        dbz_q    <= 1'b0;
                    end else begin
                        state_q <= ST_MUL;
                    end
                end
                ST_DIV: begin
                    acc_q <= div_rem_d;
                    a_q   <= div_quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= div_quo_d;
                        zero_q   <= (div_quo_d == 32'd0);
                        ovf_q    <= 1'b0;
                        dbz_q    <= 1'b0;
                    end else begin
                        state_q <= ST_DIV;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end

    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized scoreboard bench for alu_multicycle: the driver pushes the
// reference-model expectation at each launch; a negedge monitor pops and
// compares result, flags, done timing and busy duration on every done.
module tb_alu_multicycle;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_multicycle_if bus_if ();

    alu_multicycle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        dbz;
        int          cyc;
        int          nbusy;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model written from the operation definitions.
    function automatic exp_t model(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      s;
        logic [63:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        e.res = 32'd0; e.ovf = 1'b0; e.dbz = 1'b0; e.nbusy = 0; e.cyc = 0;
        case (c)
            4'd0: begin
                s = sa + sbv; e.res = s[31:0];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                s = sa - sbv; e.res = s[31:0];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: begin
                p = 64'(a) * 64'(b); e.res = p[31:0]; e.nbusy = 32;
            end
            4'd3: begin
                if (b == 32'd0) begin e.res = 32'hFFFF_FFFF; e.dbz = 1'b1; end
                else begin e.res = a / b; e.nbusy = 32; end
            end
            4'd4: e.res = a & b;
            4'd5: e.res = a | b;
            4'd6: e.res = ~(a | b);
            4'd8: e.res = a >> b[4:0];
            4'd9, 4'd11: e.res = (sa < sbv) ? 32'd1 : 32'd0;
            4'd10: e.res = a ^ b;
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Launch one operation: called just after a rising edge with busy low.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(c, a, b);
        e.cyc = cyc + ((e.nbusy != 0) ? 33 : 1);
        sb.push_back(e);
        bus_if.start = 1'b1; bus_if.alu_ctrl = c; bus_if.op_a = a; bus_if.op_b = b;
        @(posedge clk); #1;
        bus_if.start    = 1'b0;
        bus_if.alu_ctrl = 4'($urandom);
        bus_if.op_a     = $urandom;
        bus_if.op_b     = $urandom;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (bus_if.done !== 1'b1 && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        chk("done_timeout", 64'(bus_if.done), 64'd1);
    endtask

    // Cycle counter: value after rising edge k is k.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: compare each done against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                chk("done_in_reset", 64'(bus_if.done), 64'd0);
            end else begin
                if (bus_if.busy === 1'b1) busy_cnt++;
                if (bus_if.done === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        m = sb.pop_front();
                        chk("result",      64'(bus_if.result),      64'(m.res));
                        chk("zero",        64'(bus_if.zero),        64'(m.zero));
                        chk("overflow",    64'(bus_if.overflow),    64'(m.ovf));
                        chk("div_by_zero", 64'(bus_if.div_by_zero), 64'(m.dbz));
                        chk("done_cycle",  64'(cyc),                64'(m.cyc));
                        chk("busy_cycles", 64'(busy_cnt),           64'(m.nbusy));
                        chk("busy_at_done", 64'(bus_if.busy),       64'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        bus_if.start = 1'b0; bus_if.alu_ctrl = 4'd0; bus_if.op_a = 32'd0; bus_if.op_b = 32'd0;

        // Reset state
        #12;
        chk("rst_result",   64'(bus_if.result),      64'd0);
        chk("rst_zero",     64'(bus_if.zero),        64'd1);
        chk("rst_overflow", 64'(bus_if.overflow),    64'd0);
        chk("rst_dbz",      64'(bus_if.div_by_zero), 64'd0);
        chk("rst_busy",     64'(bus_if.busy),        64'd0);
        chk("rst_done",     64'(bus_if.done),        64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(4'b0000, 32'h7FFF_FFFF, 32'h1);        wait_done();
        issue(4'b0001, 32'd5, 32'd5);                wait_done();
        issue(4'b1001, 32'hFFFF_FFFF, 32'd1);        wait_done();
        issue(4'b0010, 32'h0001_0003, 32'h0000_0010); wait_done();
        issue(4'b0011, 32'd100, 32'd7);              wait_done();
        issue(4'b0011, 32'd100, 32'd0);              wait_done();
        issue(4'b0111, 32'h1234_5678, 32'h9);        wait_done();
        issue(4'b1111, 32'hFFFF_FFFF, 32'h1);        wait_done();
        issue(4'b0001, 32'h8000_0000, 32'h1);        wait_done();

        // Start while busy is ignored; start in the done cycle is accepted
        issue(4'b0010, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (5) begin @(posedge clk); #1; end
        bus_if.start = 1'b1; bus_if.alu_ctrl = 4'b0000;
        bus_if.op_a = 32'd1; bus_if.op_b = 32'd2;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_done();
        issue(4'b0000, 32'd40, 32'd2);               wait_done();
        issue(4'b0011, 32'hFFFF_FFFF, 32'd3);        wait_done();

        // Reset in the middle of a divide
        issue(4'b0011, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_result",   64'(bus_if.result),      64'd0);
        chk("abort_zero",     64'(bus_if.zero),        64'd1);
        chk("abort_overflow", 64'(bus_if.overflow),    64'd0);
        chk("abort_dbz",      64'(bus_if.div_by_zero), 64'd0);
        chk("abort_busy",     64'(bus_if.busy),        64'd0);
        chk("abort_done",     64'(bus_if.done),        64'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'b1000, 32'h8000_0000, 32'd31);       wait_done();

        // Randomized operations
        for (int i = 0; i < 300; i++) begin
            c = 4'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: begin a = 32'($urandom_range(1000, 0)); b = 32'($urandom_range(20, 1)); end
                2: a = {1'b0, 31'h7FFF_FFFF} - 32'($urandom_range(3, 0));
                default: a = a;
            endcase
            issue(c, a, b);
            wait_done();
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
